// File: rtl/adder32_slice_seq_pkg.sv
// Shared definitions for the slice-serial 32-bit adder.
//   WIDTH  : operand width in bits
//   SLICE  : width of the combinational slice adder (must match adder_slice5)
//   BEATS  : number of slice beats per add, ceil(WIDTH/SLICE)
//   PAD_W  : operand width rounded up to a whole number of slices
//   BEAT_W : width of the beat counter
package adder32_slice_seq_pkg;

  localparam int WIDTH  = 32;
  localparam int SLICE  = 5;
  localparam int BEATS  = (WIDTH + SLICE - 1) / SLICE;
  localparam int PAD_W  = BEATS * SLICE;
  localparam int BEAT_W = $clog2(BEATS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef logic [BEAT_W-1:0] beat_t;

endpackage

// File: rtl/adder32_slice_seq_slice.sv
// adder_slice5: combinational 5-bit slice adder.
// Drop-in replacements (e.g. approximate netlists) must keep this port list;
// the controller uses sum and cout exactly as produced here.
//   a, b : 5-bit slice operands
//   cin  : carry into bit 0 of the slice
//   sum  : 5-bit slice sum
//   cout : carry out of bit 4 of the slice
module adder_slice5 (
  input  logic [4:0] a,
  input  logic [4:0] b,
  input  logic       cin,
  output logic [4:0] sum,
  output logic       cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {5'b0_0000, cin};

endmodule

// File: rtl/adder32_slice_seq.sv
// adder32_slice_seq: slice-serial 32-bit adder controller.
// A single 5-bit slice adder is reused for BEATS clocks to form
// A + B + cin, with the inter-slice carry held in a register.
// Operands are accepted in IDLE; the result is presented in DONE until the
// consumer takes it.
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   in_valid  : operand request valid
//   in_ready  : controller can accept operands (IDLE only)
//   in_a/in_b : WIDTH-bit operands, sampled only at the accepting edge
//   in_cin    : carry into bit 0
//   out_valid : result valid (DONE)
//   out_ready : consumer accepts result
//   out_sum   : A+B+cin modulo 2^WIDTH, zero unless out_valid
//   out_cout  : carry out of bit WIDTH-1, zero unless out_valid
//   busy      : high in RUN or DONE
module adder32_slice_seq
  import adder32_slice_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy
);

  state_e             state;
  state_e             state_nx;
  logic [PAD_W-1:0]   a_sr;
  logic [PAD_W-1:0]   b_sr;
  logic [PAD_W-1:0]   res;
  logic               carry;
  beat_t              beat;

  logic [SLICE-1:0]   s_sum;
  logic               s_cout;
  logic               accept;
  logic               last_beat;
  logic               final_cout;

  adder_slice5 u_slice (
    .a    (a_sr[SLICE-1:0]),
    .b    (b_sr[SLICE-1:0]),
    .cin  (carry),
    .sum  (s_sum),
    .cout (s_cout)
  );

  assign accept    = in_valid && (state == IDLE);
  assign last_beat = (beat == beat_t'(BEATS - 1));

  // The carry out of bit WIDTH-1 lands inside the final slice's sum when the
  // width is not a whole number of slices; otherwise it is the final slice
  // carry, which stays in the carry register throughout DONE.
  if (WIDTH % SLICE == 0) begin : g_cout_carry
    assign final_cout = carry;
  end else begin : g_cout_res
    assign final_cout = res[WIDTH];
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic.
  // NOTE: the default assignment first covers every path, so no latch is inferred.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept)    state_nx = RUN;
      RUN:     if (last_beat) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  // Outputs. Result ports are forced to zero outside DONE so an in-flight or
  // discarded partial sum is never visible.
  always_comb begin
    in_ready  = (state == IDLE);
    busy      = (state != IDLE);
    out_valid = (state == DONE);
    out_sum   = '0;
    out_cout  = 1'b0;
    if (state == DONE) begin
      out_sum  = res[WIDTH-1:0];
      out_cout = final_cout;
    end
  end

  // Datapath: operand shift registers, slice carry, result register, beat count.
  // NOTE: all datapath registers are cleared by reset so an aborted operation
  // leaves no stale operands, carry or partial result behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr  <= '0;
      b_sr  <= '0;
      res   <= '0;
      carry <= 1'b0;
      beat  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            a_sr  <= PAD_W'(in_a);
            b_sr  <= PAD_W'(in_b);
            carry <= in_cin;
            beat  <= '0;
          end
        end
        RUN: begin
          a_sr  <= a_sr >> SLICE;
          b_sr  <= b_sr >> SLICE;
          carry <= s_cout;
          // LSB slice enters first and ends up at the bottom after BEATS shifts.
          res   <= {s_sum, res[PAD_W-1:SLICE]};
          beat  <= beat + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adder32_slice_seq.sv
module tb_adder32_slice_seq;
  import adder32_slice_seq_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic             in_cin = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             busy;

  int n_total = 0;
  int n_bad   = 0;

  localparam int N_RND = 1000;

  adder32_slice_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for out_valid, return the number of edges waited.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  // One complete directed transaction with latency and result checks.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic [31:0] exp_sum, input logic exp_cout);
    int lat;
    lat = 0;
    while (!in_ready && lat < 40) begin
      tick();
      lat++;
    end
    check({tag, "_ready"}, in_ready, 1);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_cin = cin;
    tick();
    // Scramble operands after the accepting edge; they must not matter.
    in_valid = 1'b0;
    in_a = ~a;
    in_b = ~b;
    in_cin = ~cin;
    check({tag, "_busy"}, busy, 1);
    check({tag, "_noready"}, in_ready, 0);
    wait_valid(lat);
    check({tag, "_lat"}, lat, 7);
    check({tag, "_sum"}, out_sum, exp_sum);
    check({tag, "_cout"}, out_cout, exp_cout);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_idle"}, out_valid, 0);
  endtask

  initial begin
    int lat;

    // Reset state.
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_sum", out_sum, 0);
    check("rst_cout", out_cout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Directed vectors.
    run_op("ovf",  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1);
    run_op("mix",  32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 32'hACF1_3569, 1'b0);
    run_op("max7", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b0);

    // Backpressure: result held while out_ready low; new request ignored.
    in_valid = 1'b1;
    in_a = 32'h0000_FFFF;
    in_b = 32'h0000_0001;
    in_cin = 1'b0;
    tick();
    in_valid = 1'b0;
    wait_valid(lat);
    check("bp_lat", lat, 7);
    in_valid = 1'b1;
    in_a = 32'h8000_0000;
    in_b = 32'h8000_0000;
    in_cin = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", out_valid, 1);
      check("bp_sum", out_sum, 32'h0001_0000);
      check("bp_cout", out_cout, 0);
      check("bp_in_ready", in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    check("bp_rel_in_ready", in_ready, 0);
    tick();
    out_ready = 1'b0;
    // The request stayed up through DONE and the release edge; only now idle.
    check("bp_idle_ready", in_ready, 1);
    check("bp_idle_valid", out_valid, 0);
    tick();
    in_valid = 1'b0;
    check("bp_next_busy", busy, 1);
    wait_valid(lat);
    check("bp_next_lat", lat, 7);
    check("bp_next_sum", out_sum, 32'h0000_0001);
    check("bp_next_cout", out_cout, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Asynchronous reset in the middle of RUN.
    in_valid = 1'b1;
    in_a = 32'hDEAD_BEEF;
    in_b = 32'h0BAD_F00D;
    in_cin = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("mrst_in_ready", in_ready, 1);
    check("mrst_valid", out_valid, 0);
    check("mrst_busy", busy, 0);
    check("mrst_sum", out_sum, 0);
    check("mrst_cout", out_cout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_op("post_rst", 32'h0000_0005, 32'h0000_000A, 1'b0, 32'h0000_000F, 1'b0);

    // Random traffic with stalls on both sides against a 33-bit golden sum.
    begin
      logic [32:0] exp_q[$];
      int got_n = 0;
      int dup_n = 0;
      bit timed_out = 1'b0;
      fork
        begin : producer
          for (int i = 0; i < N_RND; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            logic        rc;
            int          guard;
            repeat ($urandom_range(0, 2)) tick();
            ra = $urandom;
            rb = $urandom;
            rc = 1'($urandom_range(0, 1));
            in_valid = 1'b1;
            in_a = ra;
            in_b = rb;
            in_cin = rc;
            guard = 0;
            while (!in_ready && guard < 1000) begin
              tick();
              guard++;
            end
            if (guard >= 1000) begin
              timed_out = 1'b1;
              break;
            end
            exp_q.push_back({1'b0, ra} + {1'b0, rb} + {32'd0, rc});
            tick();
            in_valid = 1'b0;
            in_a = $urandom;
            in_b = $urandom;
          end
          in_valid = 1'b0;
        end
        begin : consumer
          int cyc = 0;
          while (got_n < N_RND && cyc < 60000) begin
            out_ready = 1'($urandom_range(0, 1));
            if (out_valid && out_ready) begin
              if (exp_q.size() == 0) begin
                dup_n++;
              end else begin
                check("rnd_res", {out_cout, out_sum}, exp_q.pop_front());
              end
              got_n++;
            end
            tick();
            cyc++;
          end
          out_ready = 1'b0;
        end
      join
      check("rnd_in_timeout", timed_out, 0);
      check("rnd_count", got_n, N_RND);
      check("rnd_dup", dup_n, 0);
      check("rnd_leftover", exp_q.size(), 0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/adder32_slice_seq.md
Name: adder32_slice_seq

Overview:
Slice-serial 32-bit adder controller. It sequences one combinational 5-bit slice adder (5-bit A, 5-bit B, carry-in → 5-bit sum, carry-out) over a full 32-bit add, one slice per clock, carrying between beats in a register. This trades latency for area: one slice instance replaces the full 32-bit partitioned adder. It sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.

Parameters:
WIDTH, 32, operand width in bits
SLICE, 5, slice adder width; must match the slice instance
BEATS, ceil(WIDTH/SLICE) = 7, derived localparam, not overridable

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous, active-low reset
in_valid  in  1  operand request valid
in_ready  out  1  controller can accept operands
in_a  in  WIDTH  operand A
in_b  in  WIDTH  operand B
in_cin  in  1  carry-in to bit 0
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_sum  out  WIDTH  A+B+cin modulo 2^WIDTH
out_cout  out  1  carry out of bit WIDTH-1
busy  out  1  high in RUN or DONE

Behaviour:
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- Reset values: in_ready=1, out_valid=0, busy=0, out_sum=0, out_cout=0. Beat counter, carry, and shift registers are cleared.
- Reset is asynchronous, any state. Asserting it mid-RUN or mid-DONE discards the operation; no partial result is ever presented.
- in_ready = (state==IDLE). No acceptance in DONE, even if out_ready is high that cycle.
- IDLE: on in_valid&&in_ready, latch in_a and in_b zero-extended to BEATS*SLICE=35 bits into A/B shift registers. Set carry<=in_cin and beat<=0, then go to RUN.
- RUN, one beat per cycle:
  - Slice inputs are the low SLICE bits of the A/B shift registers, with cin=carry.
  - carry <= slice cout.
  - A/B shift right by SLICE.
  - Slice sum shifts into the top of a 35-bit result register, LSB-slice first.
  - beat increments.
  - On beat==BEATS-1, go to DONE.
- DONE:
  - out_valid=1.
  - out_sum = result[WIDTH-1:0].
  - out_cout = result[WIDTH], which is local bit (WIDTH mod SLICE) of the final beat's sum. If WIDTH mod SLICE==0, use the final slice cout instead.
  - Outputs are held stable while out_valid&&!out_ready.
  - On out_ready, go to IDLE.
- Latency: out_valid rises exactly BEATS (7) cycles after the accepting edge. Minimum initiation interval is BEATS+2 = 9 cycles.
- in_valid during RUN/DONE is ignored. Operand inputs are sampled only at the accepting edge, so later changes have no effect.
- out_ready while !out_valid has no effect.
- The slice may be an approximate netlist. The controller uses slice sum and cout verbatim and does no correction.
- Unused result bits 33..34 are don't-care and never drive outputs.

Decomposition:
- Shared package holds:
  - FSM state enum (IDLE/RUN/DONE);
  - localparams WIDTH, SLICE, BEATS, PAD_W = BEATS*SLICE;
  - beat counter width clog2(BEATS).
- One sub-module, adder_slice5: the combinational 5-bit slice adder with ports a[4:0], b[4:0], cin → sum[4:0], cout. It is swappable for approximate variants.
- Controller logic stays flat in adder32_slice_seq.

Test Plan:
- A=0xFFFFFFFF, B=0x00000001, cin=0 → out_sum=0x00000000, out_cout=1; out_valid exactly 7 cycles after accept.
- A=0x12345678, B=0x9ABCDEF0, cin=1 → out_sum=0xACF13569, out_cout=0.
- A=0x7FFFFFFF, B=0x7FFFFFFF, cin=1 → out_sum=0xFFFFFFFF, out_cout=0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid → out_sum, out_cout, out_valid stable; in_ready=0 throughout. Assert in_valid with new operands meanwhile → not accepted; the next accept occurs only after the IDLE cycle.
- Reset mid-operation: pulse rst_n low asynchronously at beat 3 → outputs immediately return to reset values, in_ready=1. Next op 0x00000005+0x0000000A, cin=0 → 0x0000000F, cout=0.
- Random: 1000 ops with random in_valid/out_ready stalls, exact slice → every result matches the golden A+B+cin (33-bit), with no dropped or duplicated transactions.
